// File: rtl/pe_seq_pkg.sv
// Shared types and default sizing for the PE array sequencer.
package pe_seq_pkg;

   localparam int NUM_PE_DEF    = 16;
   localparam int CTX_WIDTH_DEF = 121;
   localparam int CTX_DEPTH_DEF = 16;
   localparam int ITER_W        = 16;
   localparam int CP_W          = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/pe_cfg_loader.sv
// Context-major config loader: walks PE index then slot, drops overflow words,
// and presents registered write strobes to the PE context caches.
module pe_cfg_loader
   import pe_seq_pkg::*;
#(
   parameter int NUM_PE    = NUM_PE_DEF,
   parameter int CTX_WIDTH = CTX_WIDTH_DEF,
   parameter int CTX_DEPTH = CTX_DEPTH_DEF,
   parameter int CTX_AW    = $clog2(CTX_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 accept_i,
   input  logic                 last_i,
   input  logic [CTX_WIDTH-1:0] data_i,
   input  logic                 clr_i,
   input  logic                 err_clr_i,
   output logic                 pe_wr_o,
   output logic [NUM_PE-1:0]    pe_sel_o,
   output logic [CTX_AW-1:0]    pe_addr_o,
   output logic [CTX_WIDTH-1:0] pe_data_o,
   output logic                 err_o
);
   localparam int PE_IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   logic [PE_IW-1:0]  pe_idx_q, pe_idx_d;
   logic [CTX_AW-1:0] slot_q, slot_d;
   logic              full_q, full_d;
   logic              err_q, err_d;
   logic              wr;

   assign wr    = accept_i && !full_q;
   assign err_o = err_q;

   always_comb begin
      pe_idx_d = pe_idx_q;
      slot_d   = slot_q;
      full_d   = full_q;
      err_d    = err_q;
      if (err_clr_i)
         err_d = 1'b0;
      if (accept_i && full_q)
         err_d = 1'b1;
      if (clr_i || (accept_i && last_i)) begin
         pe_idx_d = '0;
         slot_d   = '0;
         full_d   = 1'b0;
      end else if (wr) begin
         if (pe_idx_q == PE_IW'(NUM_PE - 1)) begin
            pe_idx_d = '0;
            // Last slot of last PE written: everything after this is dropped
            if (slot_q == CTX_AW'(CTX_DEPTH - 1))
               full_d = 1'b1;
            else
               slot_d = slot_q + CTX_AW'(1);
         end else begin
            pe_idx_d = pe_idx_q + PE_IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_idx_q  <= '0;
         slot_q    <= '0;
         full_q    <= 1'b0;
         err_q     <= 1'b0;
         pe_wr_o   <= 1'b0;
         pe_sel_o  <= '0;
         pe_addr_o <= '0;
         pe_data_o <= '0;
      end else begin
         pe_idx_q <= pe_idx_d;
         slot_q   <= slot_d;
         full_q   <= full_d;
         err_q    <= err_d;
         pe_wr_o  <= wr;
         if (wr) begin
            pe_sel_o  <= NUM_PE'(1) << pe_idx_q;
            pe_addr_o <= slot_q;
            pe_data_o <= data_i;
         end
      end
   end

endmodule

// File: rtl/pe_array_sequencer.sv
// CGRA PE array sequencer: config load, broadcast start and global context pointer.
// Optional RUN-cycle counter enabled by defining PE_SEQ_PERF_EN.
//
// state  | meaning
// IDLE   | ready for config words or run_req
// LOAD   | streaming context words into PE caches
// RUN    | stepping cp through num_ctx contexts x num_iter iterations
// DONE   | one-cycle completion pulse
module pe_array_sequencer
   import pe_seq_pkg::*;
#(
   parameter int NUM_PE    = NUM_PE_DEF,
   parameter int CTX_WIDTH = CTX_WIDTH_DEF,
   parameter int CTX_DEPTH = CTX_DEPTH_DEF,
   parameter int CTX_AW    = $clog2(CTX_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [CTX_WIDTH-1:0] cfg_data_i,
   input  logic                 cfg_last_i,
   input  logic                 run_req_i,
   input  logic                 abort_i,
   input  logic [CTX_AW:0]      num_ctx_i,
   input  logic [ITER_W-1:0]    num_iter_i,
   output logic                 pe_wr_o,
   output logic [NUM_PE-1:0]    pe_sel_o,
   output logic [CTX_AW-1:0]    pe_addr_o,
   output logic [CTX_WIDTH-1:0] pe_data_o,
   output logic                 pe_start_o,
   output logic [CP_W-1:0]      cp_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [31:0]          cycle_cnt_o
);
   seq_state_e        state_q, state_d;
   logic [CP_W-1:0]   cp_q, cp_d, ctx_last_q, ctx_last_d;
   logic [ITER_W-1:0] iter_q, iter_d, num_iter_q, num_iter_d;
   logic              first_q, first_d;
   logic              cfg_acc, run_acc;
   logic [CTX_AW:0]   ctx_eff;

   assign cfg_ready_o = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !abort_i;
   assign cfg_acc     = cfg_valid_i && cfg_ready_o;
   // Config has priority over a simultaneous run request
   assign run_acc     = (state_q == S_IDLE) && run_req_i && !cfg_valid_i && !abort_i;
   assign cp_o        = cp_q;
   assign busy_o      = (state_q == S_LOAD) || (state_q == S_RUN);

   always_comb begin
      ctx_eff = num_ctx_i;
      if (num_ctx_i == '0)
         ctx_eff = (CTX_AW + 1)'(1);
      else if (num_ctx_i > (CTX_AW + 1)'(CTX_DEPTH))
         ctx_eff = (CTX_AW + 1)'(CTX_DEPTH);
   end

   always_comb begin
      state_d    = state_q;
      cp_d       = cp_q;
      iter_d     = iter_q;
      first_d    = 1'b0;
      ctx_last_d = ctx_last_q;
      num_iter_d = num_iter_q;
      pe_start_o = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_acc) begin
               state_d = cfg_last_i ? S_IDLE : S_LOAD;
            end else if (run_acc) begin
               state_d    = S_RUN;
               cp_d       = '0;
               iter_d     = '0;
               first_d    = 1'b1;
               ctx_last_d = CP_W'(ctx_eff) - CP_W'(1);
               num_iter_d = num_iter_i;
            end
         end
         S_LOAD: begin
            if (cfg_acc && cfg_last_i)
               state_d = S_IDLE;
         end
         S_RUN: begin
            pe_start_o = first_q && (num_iter_q != '0);
            if (num_iter_q == '0) begin
               state_d = S_DONE;
               cp_d    = '0;
            end else if (cp_q == ctx_last_q) begin
               cp_d   = '0;
               iter_d = iter_q + ITER_W'(1);
               if (iter_d == num_iter_q)
                  state_d = S_DONE;
            end else begin
               cp_d = cp_q + CP_W'(1);
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_i) begin
         state_d = S_IDLE;
         cp_d    = '0;
         iter_d  = '0;
         first_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cp_q       <= '0;
         iter_q     <= '0;
         first_q    <= 1'b0;
         ctx_last_q <= '0;
         num_iter_q <= '0;
      end else begin
         state_q    <= state_d;
         cp_q       <= cp_d;
         iter_q     <= iter_d;
         first_q    <= first_d;
         ctx_last_q <= ctx_last_d;
         num_iter_q <= num_iter_d;
      end
   end

   pe_cfg_loader #(
      .NUM_PE    (NUM_PE),
      .CTX_WIDTH (CTX_WIDTH),
      .CTX_DEPTH (CTX_DEPTH),
      .CTX_AW    (CTX_AW)
   ) u_loader (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept_i  (cfg_acc),
      .last_i    (cfg_last_i),
      .data_i    (cfg_data_i),
      .clr_i     (abort_i),
      .err_clr_i (run_acc),
      .pe_wr_o   (pe_wr_o),
      .pe_sel_o  (pe_sel_o),
      .pe_addr_o (pe_addr_o),
      .pe_data_o (pe_data_o),
      .err_o     (err_o)
   );

`ifdef PE_SEQ_PERF_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cyc_q <= '0;
      else if (run_acc)
         cyc_q <= '0;
      else if (state_q == S_RUN)
         cyc_q <= cyc_q + 32'd1;
   end

   assign cycle_cnt_o = cyc_q;
`else
   assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed self-checking bench for pe_array_sequencer (NUM_PE=4, CTX_DEPTH=4).
module tb_pe_array_sequencer;
   localparam int NUM_PE    = 4;
   localparam int CTX_WIDTH = 121;
   localparam int CTX_DEPTH = 4;
   localparam int CTX_AW    = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cfg_valid, cfg_ready, cfg_last, run_req, abort;
   logic [CTX_WIDTH-1:0] cfg_data;
   logic [CTX_AW:0]      num_ctx;
   logic [15:0]          num_iter;
   logic                 pe_wr, pe_start, busy, done, err;
   logic [NUM_PE-1:0]    pe_sel;
   logic [CTX_AW-1:0]    pe_addr;
   logic [CTX_WIDTH-1:0] pe_data;
   logic [15:0]          cp;
   logic [31:0]          cycle_cnt;

   int total = 0;
   int bad   = 0;

`ifdef PE_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 clk = ~clk;

   pe_array_sequencer #(
      .NUM_PE(NUM_PE), .CTX_WIDTH(CTX_WIDTH), .CTX_DEPTH(CTX_DEPTH), .CTX_AW(CTX_AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_data_i(cfg_data), .cfg_last_i(cfg_last),
      .run_req_i(run_req), .abort_i(abort), .num_ctx_i(num_ctx), .num_iter_i(num_iter),
      .pe_wr_o(pe_wr), .pe_sel_o(pe_sel), .pe_addr_o(pe_addr), .pe_data_o(pe_data),
      .pe_start_o(pe_start), .cp_o(cp), .busy_o(busy), .done_o(done), .err_o(err),
      .cycle_cnt_o(cycle_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_valid = 0; cfg_last = 0; run_req = 0; abort = 0;
      cfg_data = '0; num_ctx = '0; num_iter = '0;
      tick(); tick();
      total++; if (pe_wr !== 1'b0) begin bad++; $display("FAIL rst_pe_wr got=%b exp=0", pe_wr); end
      total++; if (pe_sel !== 4'b0) begin bad++; $display("FAIL rst_pe_sel got=%b exp=0000", pe_sel); end
      total++; if (pe_addr !== 2'd0) begin bad++; $display("FAIL rst_pe_addr got=%0d exp=0", pe_addr); end
      total++; if (pe_data !== '0) begin bad++; $display("FAIL rst_pe_data got=%h exp=0", pe_data); end
      total++; if (pe_start !== 1'b0) begin bad++; $display("FAIL rst_pe_start got=%b exp=0", pe_start); end
      total++; if (cp !== 16'd0) begin bad++; $display("FAIL rst_cp got=%0d exp=0", cp); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL rst_cycle_cnt got=%0d exp=0", cycle_cnt); end
      rst_n = 1'b1;
      tick();
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_cfg_ready got=%b exp=1", cfg_ready); end
   endtask

   task automatic test_load2();
      cfg_valid = 1; cfg_data = CTX_WIDTH'(32'hC0DE_0000); cfg_last = 0;
      tick();
      total++; if (pe_wr !== 1'b1) begin bad++; $display("FAIL load2_wr0 got=%b exp=1", pe_wr); end
      total++; if (pe_sel !== 4'b0001) begin bad++; $display("FAIL load2_sel0 got=%b exp=0001", pe_sel); end
      total++; if (pe_addr !== 2'd0) begin bad++; $display("FAIL load2_addr0 got=%0d exp=0", pe_addr); end
      total++; if (pe_data !== CTX_WIDTH'(32'hC0DE_0000)) begin bad++; $display("FAIL load2_data0 got=%h exp=c0de0000", pe_data); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL load2_busy got=%b exp=1", busy); end
      cfg_data = CTX_WIDTH'(32'hC0DE_0001); cfg_last = 1;
      tick();
      cfg_valid = 0; cfg_last = 0;
      total++; if (pe_wr !== 1'b1) begin bad++; $display("FAIL load2_wr1 got=%b exp=1", pe_wr); end
      total++; if (pe_sel !== 4'b0010) begin bad++; $display("FAIL load2_sel1 got=%b exp=0010", pe_sel); end
      total++; if (pe_addr !== 2'd0) begin bad++; $display("FAIL load2_addr1 got=%0d exp=0", pe_addr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL load2_idle got=%b exp=0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL load2_err got=%b exp=0", err); end
      tick();
      total++; if (pe_wr !== 1'b0) begin bad++; $display("FAIL load2_wr_off got=%b exp=0", pe_wr); end
   endtask

   task automatic test_load5();
      for (int i = 0; i < 5; i++) begin
         cfg_valid = 1; cfg_data = CTX_WIDTH'(32'hA000 + i); cfg_last = (i == 4);
         tick();
         total++; if (pe_wr !== 1'b1) begin bad++; $display("FAIL load5_wr[%0d] got=%b exp=1", i, pe_wr); end
         total++; if (pe_sel !== 4'(1 << (i % 4))) begin bad++; $display("FAIL load5_sel[%0d] got=%b exp=%b", i, pe_sel, 4'(1 << (i % 4))); end
         total++; if (pe_addr !== 2'(i / 4)) begin bad++; $display("FAIL load5_addr[%0d] got=%0d exp=%0d", i, pe_addr, i / 4); end
      end
      cfg_valid = 0; cfg_last = 0;
      tick();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) begin
         cfg_valid = 1; cfg_data = CTX_WIDTH'(32'hB000 + i); cfg_last = (i == 16);
         tick();
         if (i < 16) begin
            total++; if (pe_wr !== 1'b1) begin bad++; $display("FAIL ovf_wr[%0d] got=%b exp=1", i, pe_wr); end
            total++; if (pe_sel !== 4'(1 << (i % 4))) begin bad++; $display("FAIL ovf_sel[%0d] got=%b exp=%b", i, pe_sel, 4'(1 << (i % 4))); end
            total++; if (pe_addr !== 2'(i / 4)) begin bad++; $display("FAIL ovf_addr[%0d] got=%0d exp=%0d", i, pe_addr, i / 4); end
            total++; if (pe_data !== CTX_WIDTH'(32'hB000 + i)) begin bad++; $display("FAIL ovf_data[%0d] got=%h", i, pe_data); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_err_early[%0d] got=%b exp=0", i, err); end
         end else begin
            total++; if (pe_wr !== 1'b0) begin bad++; $display("FAIL ovf_dropped_wr got=%b exp=0", pe_wr); end
            total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", err); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_idle got=%b exp=0", busy); end
         end
      end
      cfg_valid = 0; cfg_last = 0;
      tick();
   endtask

   task automatic test_abort_load();
      for (int i = 0; i < 2; i++) begin
         cfg_valid = 1; cfg_data = CTX_WIDTH'(32'hD000 + i); cfg_last = 0;
         tick();
      end
      cfg_valid = 0; abort = 1;
      tick();
      abort = 0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abl_idle got=%b exp=0", busy); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL abl_err_kept got=%b exp=1", err); end
      cfg_valid = 1; cfg_data = CTX_WIDTH'(32'hD0FF); cfg_last = 1;
      tick();
      cfg_valid = 0; cfg_last = 0;
      total++; if (pe_sel !== 4'b0001) begin bad++; $display("FAIL abl_sel got=%b exp=0001", pe_sel); end
      total++; if (pe_addr !== 2'd0) begin bad++; $display("FAIL abl_addr got=%0d exp=0", pe_addr); end
      tick();
   endtask

   task automatic test_run();
      num_ctx = 3'd3; num_iter = 16'd2; run_req = 1;
      tick();
      run_req = 0;
      total++; if (pe_start !== 1'b1) begin bad++; $display("FAIL run_start got=%b exp=1", pe_start); end
      total++; if (cp !== 16'd0) begin bad++; $display("FAIL run_cp[0] got=%0d exp=0", cp); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL run_err_clr got=%b exp=0", err); end
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL run_cfg_ready got=%b exp=0", cfg_ready); end
      for (int k = 1; k < 6; k++) begin
         tick();
         total++; if (cp !== 16'(k % 3)) begin bad++; $display("FAIL run_cp[%0d] got=%0d exp=%0d", k, cp, k % 3); end
         total++; if (pe_start !== 1'b0) begin bad++; $display("FAIL run_start_off[%0d] got=%b exp=0", k, pe_start); end
         total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL run_busy[%0d] got=%b%b exp=10", k, busy, done); end
      end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL run_done got=%b exp=1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_busy_done got=%b exp=0", busy); end
      total++; if (cp !== 16'd0) begin bad++; $display("FAIL run_cp_done got=%0d exp=0", cp); end
      total++; if (cycle_cnt !== (PERF ? 32'd6 : 32'd0)) begin bad++; $display("FAIL run_cycles got=%0d exp=%0d", cycle_cnt, PERF ? 6 : 0); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL run_done_pulse got=%b exp=0", done); end
      total++; if (cycle_cnt !== (PERF ? 32'd6 : 32'd0)) begin bad++; $display("FAIL run_cycles_hold got=%0d exp=%0d", cycle_cnt, PERF ? 6 : 0); end
   endtask

   task automatic test_iter0();
      num_ctx = 3'd2; num_iter = 16'd0; run_req = 1;
      tick();
      run_req = 0;
      total++; if (pe_start !== 1'b0) begin bad++; $display("FAIL it0_start got=%b exp=0", pe_start); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL it0_busy got=%b exp=1", busy); end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL it0_done got=%b exp=1", done); end
      total++; if (cycle_cnt !== (PERF ? 32'd1 : 32'd0)) begin bad++; $display("FAIL it0_cycles got=%0d exp=%0d", cycle_cnt, PERF ? 1 : 0); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL it0_done_off got=%b exp=0", done); end
   endtask

   task automatic test_ctx_bounds();
      num_ctx = 3'd0; num_iter = 16'd3; run_req = 1;
      tick();
      run_req = 0;
      total++; if (pe_start !== 1'b1) begin bad++; $display("FAIL c0_start got=%b exp=1", pe_start); end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         total++; if (cp !== 16'd0 || busy !== 1'b1) begin bad++; $display("FAIL c0_cp[%0d] got=%0d/%b exp=0/1", k, cp, busy); end
      end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL c0_done got=%b exp=1", done); end
      tick();
      num_ctx = 3'd7; num_iter = 16'd1; run_req = 1;
      tick();
      run_req = 0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         total++; if (cp !== 16'(k) || busy !== 1'b1) begin bad++; $display("FAIL clamp_cp[%0d] got=%0d/%b exp=%0d/1", k, cp, busy, k); end
      end
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL clamp_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_abort_run();
      num_ctx = 3'd3; num_iter = 16'd2; run_req = 1;
      tick();
      run_req = 0;
      tick();
      total++; if (cp !== 16'd1) begin bad++; $display("FAIL abr_cp1 got=%0d exp=1", cp); end
      abort = 1;
      tick();
      abort = 0;
      total++; if (busy !== 1'b0 || cp !== 16'd0) begin bad++; $display("FAIL abr_idle got=%b/%0d exp=0/0", busy, cp); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abr_done got=%b exp=0", done); end
      tick();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abr_no_done got=%b/%b exp=0/0", done, busy); end
   endtask

   task automatic test_cfg_run_together();
      num_ctx = 3'd2; num_iter = 16'd1;
      cfg_valid = 1; cfg_data = CTX_WIDTH'(32'hE000); cfg_last = 0; run_req = 1;
      tick();
      total++; if (busy !== 1'b1 || pe_start !== 1'b0) begin bad++; $display("FAIL both_load got=%b/%b exp=1/0", busy, pe_start); end
      total++; if (pe_wr !== 1'b1 || pe_sel !== 4'b0001) begin bad++; $display("FAIL both_wr got=%b/%b exp=1/0001", pe_wr, pe_sel); end
      cfg_data = CTX_WIDTH'(32'hE001); cfg_last = 1;
      tick();
      cfg_valid = 0; cfg_last = 0; run_req = 0;
      total++; if (busy !== 1'b0 || pe_start !== 1'b0) begin bad++; $display("FAIL both_idle got=%b/%b exp=0/0", busy, pe_start); end
      tick();
      total++; if (busy !== 1'b0 || pe_start !== 1'b0) begin bad++; $display("FAIL both_no_run got=%b/%b exp=0/0", busy, pe_start); end
   endtask

   task automatic test_async_reset();
      num_ctx = 3'd3; num_iter = 16'd2; run_req = 1;
      tick();
      run_req = 0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || cp !== 16'd0) begin bad++; $display("FAIL arst_idle got=%b/%0d exp=0/0", busy, cp); end
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_after got=%b/%b exp=0/0", busy, done); end
   endtask

   initial begin
      test_reset();
      test_load2();
      test_load5();
      test_overflow();
      test_abort_load();
      test_run();
      test_iter0();
      test_ctx_bounds();
      test_abort_run();
      test_cfg_run_together();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
